// File: rtl/hilo_muldiv.sv
// MIPS HI/LO multiply/divide unit: iterative radix-2 shift-add multiply and
// restoring divide over WIDTH cycles, plus MTHI/MTLO register writes.
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  localparam logic [5:0] FUN_MTHI  = 6'b010001;
  localparam logic [5:0] FUN_MTLO  = 6'b010011;
  localparam logic [5:0] FUN_MULT  = 6'b011000;
  localparam logic [5:0] FUN_MULTU = 6'b011001;
  localparam logic [5:0] FUN_DIV   = 6'b011010;
  localparam logic [5:0] FUN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [DW-1:0] neg_dw(input logic [DW-1:0] v);
    return ~v + DW'(1);
  endfunction

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic [DW-1:0]    acc_q;
  logic             busy_q, done_q, is_div_q, neg_q, rem_neg_q;

  logic             signed_op_d, a_neg_d, b_neg_d;
  logic [WIDTH-1:0] mag_a_d, mag_b_d;
  logic [WIDTH:0]   mul_sum_d, div_shift_d;
  logic [WIDTH+1:0] div_diff_d;
  logic             div_ok_d;
  logic [DW-1:0]    acc_d, prod_d;
  logic [WIDTH-1:0] fix_hi_d, fix_lo_d;

  // Operand magnitudes and sign flags captured on acceptance
  always_comb begin
    signed_op_d = ~funct_i[0];
    a_neg_d     = signed_op_d & op_a_i[WIDTH-1];
    b_neg_d     = signed_op_d & op_b_i[WIDTH-1];
    mag_a_d     = a_neg_d ? neg_w(op_a_i) : op_a_i;
    mag_b_d     = b_neg_d ? neg_w(op_b_i) : op_b_i;
  end

  // One iteration step; the accumulator holds {upper, lower} for both ops
  always_comb begin
    mul_sum_d   = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    div_shift_d = {acc_q[DW-1:WIDTH], acc_q[WIDTH-1]};
    div_diff_d  = {1'b0, div_shift_d} - {2'b00, b_q};
    div_ok_d    = ~div_diff_d[WIDTH+1];
    if (is_div_q) begin
      acc_d = {(div_ok_d ? div_diff_d[WIDTH-1:0] : div_shift_d[WIDTH-1:0]),
               acc_q[WIDTH-2:0], div_ok_d};
    end else begin
      acc_d = {mul_sum_d, acc_q[WIDTH-1:1]};
    end
  end

  // Sign correction; a zero divisor keeps the all-ones quotient, and the
  // remainder correction then restores the original dividend into HI
  always_comb begin
    prod_d = neg_q ? neg_dw(acc_q) : acc_q;
    if (is_div_q) begin
      fix_lo_d = (neg_q && (b_q != {WIDTH{1'b0}})) ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
      fix_hi_d = rem_neg_q ? neg_w(acc_q[DW-1:WIDTH]) : acc_q[DW-1:WIDTH];
    end else begin
      fix_lo_d = prod_d[WIDTH-1:0];
      fix_hi_d = prod_d[DW-1:WIDTH];
    end
  end

  // Control FSM with registered busy/done and HI/LO ownership
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CW{1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      b_q       <= {WIDTH{1'b0}};
      acc_q     <= {DW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      is_div_q  <= 1'b0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            case (funct_i)
              FUN_MULT, FUN_MULTU, FUN_DIV, FUN_DIVU: begin
                acc_q     <= {{WIDTH{1'b0}}, mag_a_d};
                b_q       <= mag_b_d;
                is_div_q  <= funct_i[1];
                neg_q     <= a_neg_d ^ b_neg_d;
                rem_neg_q <= a_neg_d;
                cnt_q     <= {CW{1'b0}};
                busy_q    <= 1'b1;
                state_q   <= ST_CALC;
              end
              FUN_MTHI: hi_q <= op_a_i;
              FUN_MTLO: lo_q <= op_a_i;
              default: ;
            endcase
          end
        end
        ST_CALC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_FIX;
          end
        end
        ST_FIX: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Self-checking bench for hilo_muldiv: directed vector table, hand-written
// corner sequences, and randomized ops against an arithmetic reference model.
module tb_hilo_muldiv;

  localparam logic [5:0] FUN_MFHI  = 6'b010000;
  localparam logic [5:0] FUN_MTHI  = 6'b010001;
  localparam logic [5:0] FUN_MTLO  = 6'b010011;
  localparam logic [5:0] FUN_MULT  = 6'b011000;
  localparam logic [5:0] FUN_MULTU = 6'b011001;
  localparam logic [5:0] FUN_DIV   = 6'b011010;
  localparam logic [5:0] FUN_DIVU  = 6'b011011;

  logic        clk, reset, start;
  logic [5:0]  funct;
  logic [31:0] op_a, op_b, hi, lo;
  logic        busy, done;

  int checks = 0;
  int errors = 0;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .funct_i(funct),
    .op_a_i(op_a), .op_b_i(op_b), .busy_o(busy), .done_o(done),
    .hi_o(hi), .lo_o(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference result {hi, lo} from plain integer arithmetic
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f)
      FUN_MULT:  return 64'(sa * sb);
      FUN_MULTU: return 64'(ua * ub);
      FUN_DIV: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = int'(sa / sb);
        r = int'(sa % sb);
        return {32'(r), 32'(q)};
      end
      FUN_DIVU: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Issue one mul/div and check the busy window, done pulse and HI/LO
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string tag);
    bit busy_ok = 1'b1;
    bit done_ok = 1'b1;
    @(negedge clk);
    start = 1'b1; funct = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; funct = FUN_MFHI;
    for (int i = 0; i < 33; i++) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done !== 1'b0) done_ok = 1'b0;
      @(posedge clk); #1;
    end
    chk({tag, " busy_window"}, 64'(busy_ok), 64'd1);
    chk({tag, " no_early_done"}, 64'(done_ok), 64'd1);
    chk({tag, " busy_end"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " hilo"}, {hi, lo}, exp);
  endtask

  vec_t vecs[10];

  initial begin
    bit          ok;
    logic [5:0]  f;
    logic [31:0] a, b;

    vecs[0] = '{FUN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{FUN_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[2] = '{FUN_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{FUN_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF};
    vecs[4] = '{FUN_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{FUN_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[6] = '{FUN_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[7] = '{FUN_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{FUN_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[9] = '{FUN_DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF};

    reset = 1'b1; start = 1'b0; funct = FUN_MFHI; op_a = 32'h0; op_b = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, $sformatf("vec%0d", i));
    end

    // MTHI then MTLO in consecutive cycles
    @(negedge clk);
    start = 1'b1; funct = FUN_MTHI; op_a = 32'h1234_5678;
    @(posedge clk); #1;
    chk("mthi_hi", 64'(hi), 64'h1234_5678);
    chk("mthi_busy", 64'(busy), 64'd0);
    funct = FUN_MTLO; op_a = 32'h9ABC_DEF0;
    @(posedge clk); #1;
    start = 1'b0; funct = FUN_MFHI;
    chk("mtlo_lo", 64'(lo), 64'h9ABC_DEF0);
    chk("mtlo_hi_kept", 64'(hi), 64'h1234_5678);
    chk("mtlo_busy", 64'(busy), 64'd0);

    // MTLO while busy must be dropped
    @(negedge clk);
    start = 1'b1; funct = FUN_MULTU; op_a = 32'd2; op_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c < 34; c++) begin
      if (c == 5) begin
        start = 1'b1; funct = FUN_MTLO; op_a = 32'hDEAD_BEEF;
      end else begin
        start = 1'b0; funct = FUN_MFHI;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("busy_mtlo_done", 64'(done), 64'd1);
    chk("busy_mtlo_hilo", {hi, lo}, 64'd6);

    // Reset in the middle of a divide
    @(negedge clk);
    start = 1'b1; funct = FUN_DIVU; op_a = 32'd100; op_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hilo", {hi, lo}, 64'd0);
    ok = 1'b1;
    repeat (40) begin
      if (done !== 1'b0 || busy !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    chk("midrst_no_done", 64'(ok), 64'd1);
    run_op(FUN_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, "after_reset");

    // Randomized mul/div against the reference model
    for (int n = 0; n < 150; n++) begin
      case ($urandom_range(3, 0))
        0: f = FUN_MULT;
        1: f = FUN_MULTU;
        2: f = FUN_DIV;
        default: f = FUN_DIVU;
      endcase
      a = $urandom();
      b = $urandom();
      if ($urandom_range(7, 0) == 0) b = 32'h0;
      if ($urandom_range(7, 0) == 1) b = $urandom_range(15, 0);
      if ($urandom_range(7, 0) == 2) a = 32'h8000_0000;
      run_op(f, a, b, model(f, a, b), $sformatf("rnd%0d f=%b a=%h b=%h", n, f, a, b));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
